// File: rtl/freqdiv_multi.sv
// Multi-channel programmable clock divider: per-channel period/high-time, end-of-period tick,
// shadowed configuration applied only on period boundaries, sync restart or while idle.
module freqdiv_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned WIDTH      = 27,
  parameter int unsigned DEF_PERIOD = 100000000,
  parameter int unsigned DEF_HIGH   = 50000000,
  localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk100M,
  input  logic                clr,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic [WIDTH-1:0]    cfg_high,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] cfg_pend,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [WIDTH-1:0] DefPeriod = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] DefHigh   = WIDTH'(DEF_HIGH);

  logic ch_ok;
  logic period_ok;
  logic wr_ok;
  logic cfg_err_q;

  // When CHANNELS fills the cfg_ch encoding every index is valid.
  if ((32'd1 << CW) == CHANNELS) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (32'(cfg_ch) < CHANNELS);
  end

  assign period_ok = (cfg_period >= WIDTH'(2));
  assign wr_ok     = cfg_we && ch_ok && period_ok;

  always_ff @(posedge clk100M or posedge clr) begin
    if (clr) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !(ch_ok && period_ok);
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_a_q, p_a_d, h_a_q, h_a_d;
    logic [WIDTH-1:0] p_s_q, p_s_d, h_s_q, h_s_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr;
    logic             wrap;
    logic             apply;

    assign wr    = wr_ok && (cfg_ch == CW'(i));
    assign wrap  = (state_q == StRun) && (cnt_q == p_a_q - WIDTH'(1));
    assign apply = (state_q == StIdle) || sync || wrap;

    // Apply reads the old shadow, so a write landing on the apply edge stays pending.
    always_comb begin
      p_a_d  = p_a_q;
      h_a_d  = h_a_q;
      p_s_d  = p_s_q;
      h_s_d  = h_s_q;
      pend_d = pend_q;
      if (apply) begin
        p_a_d  = p_s_q;
        h_a_d  = h_s_q;
        pend_d = 1'b0;
      end
      if (wr) begin
        p_s_d  = cfg_period;
        h_s_d  = cfg_high;
        pend_d = 1'b1;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        StIdle: begin
          if (en[i]) begin
            state_d = StRun;
            cnt_d   = '0;
          end
        end
        default: begin
          if (!en[i]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (sync || wrap) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
      endcase
      // Outputs registered from next-state values so they line up with cnt_q.
      clk_d  = (state_d == StRun) && (cnt_d < h_a_d);
      tick_d = (state_d == StRun) && (cnt_d == p_a_d - WIDTH'(1));
    end

    always_ff @(posedge clk100M or posedge clr) begin
      if (clr) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        p_a_q   <= DefPeriod;
        h_a_q   <= DefHigh;
        p_s_q   <= DefPeriod;
        h_s_q   <= DefHigh;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        p_a_q   <= p_a_d;
        h_a_q   <= h_a_d;
        p_s_q   <= p_s_d;
        h_s_q   <= h_s_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
        tick_q  <= tick_d;
      end
    end

    assign clk_out[i]  = clk_q;
    assign tick[i]     = tick_q;
    assign cfg_pend[i] = pend_q;
  end

endmodule

// File: tb/tb_freqdiv_multi.sv
// Scoreboard bench for freqdiv_multi: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_freqdiv_multi;

  logic clk100M = 1'b0;
  always #5 clk100M = ~clk100M;

  logic       clr, sync, cfg_we, cfg_we3;
  logic [1:0] en;
  logic [0:0] cfg_ch;
  logic [1:0] cfg_ch3;
  logic [7:0] cfg_period, cfg_high;
  logic       cfg_err, cfg_err3;
  logic [1:0] cfg_pend, clk_out, tick;
  logic [2:0] pend3, clk3, tick3;

  freqdiv_multi #(.CHANNELS(2), .WIDTH(8), .DEF_PERIOD(10), .DEF_HIGH(5)) u_dut (
    .clk100M    (clk100M),
    .clr        (clr),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err),
    .cfg_pend   (cfg_pend),
    .clk_out    (clk_out),
    .tick       (tick)
  );

  // Three-channel instance so an out-of-range channel index is encodable.
  freqdiv_multi #(.CHANNELS(3), .WIDTH(8), .DEF_PERIOD(10), .DEF_HIGH(5)) u_dut3 (
    .clk100M    (clk100M),
    .clr        (clr),
    .en         (3'b000),
    .sync       (sync),
    .cfg_we     (cfg_we3),
    .cfg_ch     (cfg_ch3),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_err    (cfg_err3),
    .cfg_pend   (pend3),
    .clk_out    (clk3),
    .tick       (tick3)
  );

  typedef struct packed {
    logic [1:0] co;
    logic [1:0] tk;
    logic [1:0] pend;
    logic       err;
    logic       err3;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Expected-behaviour bookkeeping: counter value, active and scheduled config per channel.
  int         cnt_m[2];
  int         per[2];
  int         hi[2];
  int         s_per[2];
  int         s_hi[2];
  logic [1:0] on, restart, sched, pend_exp;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
  endtask

  always @(negedge clk100M) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("clk_out", clk_out, e.co);
      chk("tick", tick, e.tk);
      chk("cfg_pend", cfg_pend, e.pend);
      chk("cfg_err", {1'b0, cfg_err}, {1'b0, e.err});
      chk("cfg_err_3ch", {1'b0, cfg_err3}, {1'b0, e.err3});
    end
  end

  task automatic model_reset();
    on       = 2'b00;
    restart  = 2'b00;
    sched    = 2'b00;
    pend_exp = 2'b00;
    for (int c = 0; c < 2; c++) begin
      cnt_m[c] = 0;
      per[c]   = 10;
      hi[c]    = 5;
    end
  endtask

  task automatic sched_cfg(input int c, input int p, input int h);
    sched[c] = 1'b1;
    s_per[c] = p;
    s_hi[c]  = h;
  endtask

  // One clock: wr marks channels whose write is accepted at this edge.
  task automatic cyc(input logic [1:0] wr, input logic err, input logic err3);
    exp_t e;
    @(posedge clk100M);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (on[c]) begin
        if (restart[c] || cnt_m[c] == per[c] - 1) cnt_m[c] = 0;
        else cnt_m[c] = cnt_m[c] + 1;
        if (cnt_m[c] == 0 && sched[c]) begin
          per[c]      = s_per[c];
          hi[c]       = s_hi[c];
          sched[c]    = 1'b0;
          pend_exp[c] = 1'b0;
        end
      end
      restart[c] = 1'b0;
      if (wr[c]) pend_exp[c] = 1'b1;
      e.co[c] = on[c] && (cnt_m[c] < hi[c]);
      e.tk[c] = on[c] && (cnt_m[c] == per[c] - 1);
    end
    e.pend = pend_exp;
    e.err  = err;
    e.err3 = err3;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running, expected finished", $time);
    $fatal(1);
  end

  initial begin
    exp_t z;
    clr = 1'b0; en = 2'b00; sync = 1'b0; cfg_we = 1'b0; cfg_we3 = 1'b0;
    cfg_ch = 1'b0; cfg_ch3 = 2'd0; cfg_period = 8'd0; cfg_high = 8'd0;
    model_reset();
    #1 clr = 1'b1;
    repeat (3) cyc(2'b00, 1'b0, 1'b0);
    clr = 1'b0;
    cyc(2'b00, 1'b0, 1'b0);

    // Enable both: default 5 high / 5 low, tick on the last low cycle.
    en = 2'b11; on = 2'b11; restart = 2'b11;
    repeat (21) cyc(2'b00, 1'b0, 1'b0);
    repeat (2) cyc(2'b00, 1'b0, 1'b0);

    // ch1 P=4 H=1 mid-period: pending until the 10-cycle period completes.
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd4; cfg_high = 8'd1;
    cyc(2'b10, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(1, 4, 1);
    repeat (20) cyc(2'b00, 1'b0, 1'b0);

    // Rejections: P=1, then an out-of-range channel; then P=2 is accepted.
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd1; cfg_high = 8'd3;
    cyc(2'b00, 1'b1, 1'b0);
    cfg_we = 1'b0;
    cyc(2'b00, 1'b0, 1'b0);
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_period = 8'd6; cfg_high = 8'd2;
    cyc(2'b00, 1'b0, 1'b1);
    cfg_ch3 = 2'd0; cfg_period = 8'd2; cfg_high = 8'd1;
    cyc(2'b00, 1'b0, 1'b0);
    cfg_we3 = 1'b0;
    cyc(2'b00, 1'b0, 1'b0);

    // H=0 then H=12 with P=10 on ch1.
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd10; cfg_high = 8'd0;
    cyc(2'b10, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(1, 10, 0);
    repeat (24) cyc(2'b00, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_ch = 1'b1; cfg_period = 8'd10; cfg_high = 8'd12;
    cyc(2'b10, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(1, 10, 12);
    repeat (24) cyc(2'b00, 1'b0, 1'b0);

    // Pending ch0 write applied by sync, both channels restart together.
    for (int k = 0; k < 20 && cnt_m[0] != 2; k++) cyc(2'b00, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd6; cfg_high = 8'd3;
    cyc(2'b01, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(0, 6, 3);
    repeat (2) cyc(2'b00, 1'b0, 1'b0);
    sync = 1'b1; restart = 2'b11;
    cyc(2'b00, 1'b0, 1'b0);
    sync = 1'b0;
    cyc(2'b00, 1'b0, 1'b0);

    // Asynchronous clear while both outputs are high.
    @(posedge clk100M);
    #1;
    clr = 1'b1;
    z = '0;
    sb.push_back(z);
    model_reset();
    repeat (2) cyc(2'b00, 1'b0, 1'b0);
    clr = 1'b0; on = 2'b11; restart = 2'b11;
    cyc(2'b00, 1'b0, 1'b0);

    // Write at the wrap edge: older shadow applies now, the new one a period later.
    repeat (2) cyc(2'b00, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd4; cfg_high = 8'd2;
    cyc(2'b01, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(0, 4, 2);
    for (int k = 0; k < 20 && cnt_m[0] != per[0] - 1; k++) cyc(2'b00, 1'b0, 1'b0);
    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_period = 8'd6; cfg_high = 8'd1;
    cyc(2'b01, 1'b0, 1'b0);
    cfg_we = 1'b0; sched_cfg(0, 6, 1);
    repeat (16) cyc(2'b00, 1'b0, 1'b0);

    // Disable: outputs drop after the edge.
    en = 2'b00; on = 2'b00;
    repeat (3) cyc(2'b00, 1'b0, 1'b0);

    @(negedge clk100M);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
